// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 8;

  // Select width for a register count; callers keep NREGS a power of two >= 2.
  function automatic int unsigned calc_aw(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

  // Cause of a sticky protocol error, highest priority first.
  typedef enum logic [1:0] {
    ErrNone,
    ErrXz,
    ErrDoubleRsv,
    ErrUnrsvWb
  } err_cause_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage bus of the register file: two read ports, writeback and reserve.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS
);
  localparam int unsigned AW = calc_aw(NREGS);

  logic [AW-1:0]    read1RegSel;
  logic [AW-1:0]    read2RegSel;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             read1Busy;
  logic             read2Busy;
  logic [AW-1:0]    writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             writeEn;
  logic [AW-1:0]    rsvRegSel;
  logic             rsvEn;
  logic             err;

  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn, rsvRegSel, rsvEn,
    input  read1Data, read2Data, read1Busy, read2Busy, err
  );

  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn, rsvRegSel, rsvEn,
    output read1Data, read2Data, read1Busy, read2Busy, err
  );
endinterface

// File: rtl/rf_entry.sv
// One register: data flop with write enable plus its pending (scoreboard) bit.
module rf_entry #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rsv_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pend_o
);
  logic [WIDTH-1:0] data_q;
  logic             pend_q;

  // Data capture on write; a same-cycle reservation wins over the retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      if (we_i) begin
        data_q <= wdata_i;
      end
      if (rsv_i) begin
        pend_q <= 1'b1;
      end else if (we_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign data_o = data_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-to-read bypass, per-register pending bits and sticky error.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW = calc_aw(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] we_dec;
  logic [NREGS-1:0] rsv_dec;
  logic             fwd1;
  logic             fwd2;
  logic             xz;
  logic             err_q;
  logic             err_d;
  err_cause_e       cause;

  // One-hot decode of the write and reserve selects.
  always_comb begin
    we_dec  = '0;
    rsv_dec = '0;
    if (bus.writeEn) we_dec[bus.writeRegSel] = 1'b1;
    if (bus.rsvEn)   rsv_dec[bus.rsvRegSel]  = 1'b1;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_entry
    rf_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we_dec[i]),
      .wdata_i (bus.writeData),
      .rsv_i   (rsv_dec[i]),
      .data_o  (regs[i]),
      .pend_o  (pend[i])
    );
  end

  // Read muxes; a matching write in flight forwards its data and hides the retiring pend bit.
  always_comb begin
    fwd1 = (BYPASS != 0) && bus.writeEn && (bus.writeRegSel == bus.read1RegSel);
    fwd2 = (BYPASS != 0) && bus.writeEn && (bus.writeRegSel == bus.read2RegSel);
    bus.read1Data = fwd1 ? bus.writeData : regs[bus.read1RegSel];
    bus.read2Data = fwd2 ? bus.writeData : regs[bus.read2RegSel];
    bus.read1Busy = pend[bus.read1RegSel] & ~fwd1;
    bus.read2Busy = pend[bus.read2RegSel] & ~fwd2;
  end

  // X/Z on any control or select is only observable in four-state simulation.
`ifndef SYNTHESIS
  always_comb begin
    xz = !rst && $isunknown({bus.writeEn, bus.rsvEn, bus.writeRegSel, bus.rsvRegSel,
                             bus.read1RegSel, bus.read2RegSel});
  end
`else
  assign xz = 1'b0;
`endif

  // Classify this cycle's protocol violation, if any.
  always_comb begin
    cause = ErrNone;
    if (xz) begin
      cause = ErrXz;
    end else if (bus.rsvEn && pend[bus.rsvRegSel] &&
                 !(bus.writeEn && (bus.writeRegSel == bus.rsvRegSel))) begin
      cause = ErrDoubleRsv;
    end else if (bus.writeEn && !pend[bus.writeRegSel]) begin
      cause = ErrUnrsvWb;
    end
    err_d = err_q | (cause != ErrNone);
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst;
  logic rst_c;
  int   n_cmp;
  int   n_bad;

  regfile_sb_if #(.WIDTH(16), .NREGS(8))  ifa ();
  regfile_sb_if #(.WIDTH(16), .NREGS(8))  ifb ();
  regfile_sb_if #(.WIDTH(32), .NREGS(32)) ifc ();

  regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  regfile_sb #(.WIDTH(16), .NREGS(8), .BYPASS(0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  regfile_sb #(.WIDTH(32), .NREGS(32), .BYPASS(1)) u_c (
    .clk (clk),
    .rst (rst_c),
    .bus (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    ifa.writeEn = 1'b0;
    ifa.rsvEn   = 1'b0;
  endtask

  task automatic a_rsv(input logic [2:0] r);
    ifa.writeEn   = 1'b0;
    ifa.rsvEn     = 1'b1;
    ifa.rsvRegSel = r;
  endtask

  task automatic a_wr(input logic [2:0] r, input logic [15:0] d);
    ifa.writeEn     = 1'b1;
    ifa.writeRegSel = r;
    ifa.writeData   = d;
    ifa.rsvEn       = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    rst_c = 1'b1;
    ifa.read1RegSel = '0; ifa.read2RegSel = '0; ifa.writeRegSel = '0; ifa.writeData = '0;
    ifa.writeEn = 1'b0; ifa.rsvRegSel = '0; ifa.rsvEn = 1'b0;
    ifb.read1RegSel = '0; ifb.read2RegSel = '0; ifb.writeRegSel = '0; ifb.writeData = '0;
    ifb.writeEn = 1'b0; ifb.rsvRegSel = '0; ifb.rsvEn = 1'b0;
    ifc.read1RegSel = '0; ifc.read2RegSel = '0; ifc.writeRegSel = '0; ifc.writeData = '0;
    ifc.writeEn = 1'b0; ifc.rsvRegSel = '0; ifc.rsvEn = 1'b0;

    #2;
    ifa.read1RegSel = 3'd3;
    #1;
    check("rst_data", {16'h0, ifa.read1Data}, 32'h0);
    check("rst_busy", {31'h0, ifa.read1Busy}, 32'h0);
    check("rst_err",  {31'h0, ifa.err},       32'h0);
    #9;
    rst   = 1'b0;
    rst_c = 1'b0;

    // Reserve r3, then write 0x1234 (bypassed the same cycle), read back next cycle.
    step(); a_rsv(3'd3); #1;
    check("rsv_same_cycle_busy", {31'h0, ifa.read1Busy}, 32'h0);
    step(); a_wr(3'd3, 16'h1234); #1;
    check("wr_bypass_data", {16'h0, ifa.read1Data}, 32'h1234);
    check("wr_bypass_busy", {31'h0, ifa.read1Busy}, 32'h0);
    step(); a_idle(); #1;
    check("wr_r3_data", {16'h0, ifa.read1Data}, 32'h1234);
    check("wr_r3_busy", {31'h0, ifa.read1Busy}, 32'h0);
    check("wr_r3_err",  {31'h0, ifa.err},       32'h0);

    // Bypass on port 2 (A) versus stored value only (B).
    step(); a_rsv(3'd5); #1;
    step();
    a_wr(3'd5, 16'hBEEF); ifa.read2RegSel = 3'd5;
    ifb.writeEn = 1'b1; ifb.writeRegSel = 3'd5; ifb.writeData = 16'hBEEF; ifb.read2RegSel = 3'd5;
    #1;
    check("byp1_r5", {16'h0, ifa.read2Data}, 32'hBEEF);
    check("byp0_r5_old", {16'h0, ifb.read2Data}, 32'h0);
    step(); a_idle(); ifb.writeEn = 1'b0; #1;
    check("byp0_r5_new", {16'h0, ifb.read2Data}, 32'hBEEF);
    check("byp1_r5_hold", {16'h0, ifa.read2Data}, 32'hBEEF);

    // Reserve r2, busy next cycle, writeback clears it combinationally.
    step(); a_rsv(3'd2); ifa.read1RegSel = 3'd2; #1;
    check("r2_busy_now", {31'h0, ifa.read1Busy}, 32'h0);
    step(); a_idle(); #1;
    check("r2_busy_next", {31'h0, ifa.read1Busy}, 32'h1);
    step(); a_wr(3'd2, 16'h00FF); #1;
    check("r2_wb_busy", {31'h0, ifa.read1Busy}, 32'h0);
    check("r2_wb_data", {16'h0, ifa.read1Data}, 32'h00FF);
    step(); a_idle(); #1;
    check("r2_pend_clr", {31'h0, ifa.read1Busy}, 32'h0);
    check("r2_data",     {16'h0, ifa.read1Data}, 32'h00FF);

    // Reserve r6, then write and re-reserve r6 in the same cycle.
    step(); a_rsv(3'd6); ifa.read1RegSel = 3'd6; #1;
    step(); a_wr(3'd6, 16'h6666); ifa.rsvEn = 1'b1; ifa.rsvRegSel = 3'd6; #1;
    check("r6_wr_rsv_busy", {31'h0, ifa.read1Busy}, 32'h0);
    step(); a_idle(); #1;
    check("r6_data", {16'h0, ifa.read1Data}, 32'h6666);
    check("r6_busy", {31'h0, ifa.read1Busy}, 32'h1);
    check("r6_err",  {31'h0, ifa.err},       32'h0);

    // Double reservation of r1.
    step(); a_rsv(3'd1); #1;
    step(); a_rsv(3'd1); #1;
    check("dbl_rsv_first", {31'h0, ifa.err}, 32'h0);
    step(); a_idle(); ifa.read2RegSel = 3'd3; #1;
    check("dbl_rsv_err", {31'h0, ifa.err}, 32'h1);
    check("port2_r3",    {16'h0, ifa.read2Data}, 32'h1234);
    step(); #1;
    check("err_sticky", {31'h0, ifa.err}, 32'h1);

    // Reset mid-run, then an unreserved writeback to r4.
    rst = 1'b1; #1;
    check("rst2_err",  {31'h0, ifa.err},       32'h0);
    check("rst2_data", {16'h0, ifa.read2Data}, 32'h0);
    #1; rst = 1'b0;
    step(); a_wr(3'd4, 16'h5555); #1;
    check("unrsv_wb_before", {31'h0, ifa.err}, 32'h0);
    step(); a_idle(); #1;
    check("unrsv_wb_err", {31'h0, ifa.err}, 32'h1);

    // 32x32 instance: asynchronous reset with r31 written and pending.
    step(); ifc.rsvEn = 1'b1; ifc.rsvRegSel = 5'd31; ifc.read1RegSel = 5'd31; #1;
    step();
    ifc.writeEn = 1'b1; ifc.writeRegSel = 5'd31; ifc.writeData = 32'hDEADBEEF; #1;
    step(); ifc.writeEn = 1'b0; ifc.rsvEn = 1'b0; #1;
    check("c_r31_data", ifc.read1Data, 32'hDEADBEEF);
    check("c_r31_busy", {31'h0, ifc.read1Busy}, 32'h1);
    check("c_err", {31'h0, ifc.err}, 32'h0);
    #1; rst_c = 1'b1; #1;
    check("c_rst_data", ifc.read1Data, 32'h0);
    check("c_rst_busy", {31'h0, ifc.read1Busy}, 32'h0);
    #1; rst_c = 1'b0;
    step(); #1;
    check("c_after_rst", ifc.read1Data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
